// File: rtl/crc_checker.sv
// Receive-side CRC-8 checker: runs each frame byte (FCS included) through a
// bit-serial LFSR and reports a pass/fail verdict at end of frame.
module crc_checker #(
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00,
  parameter int         MIN_BYTES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rData,
  input  logic       newByte,
  input  logic       frameEnd,
  output logic       busy,
  output logic [7:0] crc_byte,
  output logic       crc_valid,
  output logic       crc_ok,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

  localparam logic [7:0] MIN_CNT = 8'(MIN_BYTES);

  state_t     state;
  logic [7:0] sreg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [7:0] buf_byte;
  logic       buf_full;
  logic       end_pending;
  logic [7:0] next_crc;
  logic [7:0] cnt_inc;
  logic       fb;

  always_comb begin
    fb       = crc_byte[7] ^ sreg[bit_cnt];
    next_crc = {crc_byte[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    cnt_inc  = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
  end

  assign busy = (state != IDLE) || buf_full || end_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sreg        <= 8'h00;
      bit_cnt     <= 3'd7;
      byte_cnt    <= 8'h00;
      buf_byte    <= 8'h00;
      buf_full    <= 1'b0;
      end_pending <= 1'b0;
      crc_byte    <= INIT;
      crc_valid   <= 1'b0;
      crc_ok      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (newByte) begin
            sreg     <= rData;
            bit_cnt  <= 3'd7;
            byte_cnt <= cnt_inc;
            state    <= SHIFT;
            if (frameEnd) end_pending <= 1'b1;
          end else if (frameEnd) begin
            state <= EVAL;
          end
        end

        SHIFT: begin
          crc_byte <= next_crc;
          bit_cnt  <= bit_cnt - 3'd1;
          if (frameEnd) end_pending <= 1'b1;
          // On the last bit the buffer drains, so a byte arriving now never overruns.
          if (bit_cnt == 3'd0) begin
            if (buf_full) begin
              sreg <= buf_byte;
              if (newByte) begin
                buf_byte <= rData;
                byte_cnt <= cnt_inc;
              end else begin
                buf_full <= 1'b0;
              end
            end else if (newByte) begin
              sreg     <= rData;
              byte_cnt <= cnt_inc;
            end else if (end_pending || frameEnd) begin
              end_pending <= 1'b0;
              state       <= EVAL;
            end else begin
              state <= IDLE;
            end
          end else if (newByte) begin
            if (buf_full) begin
              overrun <= 1'b1;
            end else begin
              buf_byte <= rData;
              buf_full <= 1'b1;
              byte_cnt <= cnt_inc;
            end
          end
        end

        EVAL: begin
          crc_valid   <= 1'b1;
          crc_ok      <= (crc_byte == 8'h00) && (byte_cnt >= MIN_CNT) && !overrun;
          crc_byte    <= INIT;
          overrun     <= 1'b0;
          end_pending <= 1'b0;
          if (newByte) begin
            sreg     <= rData;
            bit_cnt  <= 3'd7;
            byte_cnt <= 8'd1;
            state    <= SHIFT;
            if (frameEnd) end_pending <= 1'b1;
          end else begin
            byte_cnt <= 8'h00;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_checker.sv
// Directed and randomized checks of crc_checker against a byte-wise CRC-8 model.
module tb_crc_checker;

  logic       clk;
  logic       reset;
  logic [7:0] rData;
  logic       newByte;
  logic       frameEnd;
  logic       busy;
  logic [7:0] crc_byte;
  logic       crc_valid;
  logic       crc_ok;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] modelCrc;
  int         modelCount;
  logic       modelOverrun;

  crc_checker dut (
    .clk(clk), .reset(reset), .rData(rData), .newByte(newByte),
    .frameEnd(frameEnd), .busy(busy), .crc_byte(crc_byte),
    .crc_valid(crc_valid), .crc_ok(crc_ok), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference CRC-8 (poly 0x07): fold the byte in, then divide eight times.
  function automatic logic [7:0] crcStep(logic [7:0] c, logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic nb, input logic [7:0] d, input logic fe);
    newByte  = nb;
    rData    = d;
    frameEnd = fe;
    tick();
    newByte  = 1'b0;
    frameEnd = 1'b0;
  endtask

  task automatic modelReset();
    modelCrc     = 8'h00;
    modelCount   = 0;
    modelOverrun = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    applyStimulus(1'b1, b, 1'b0);
    modelCrc = crcStep(modelCrc, b);
    modelCount++;
    repeat (gap - 1) tick();
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkOutput({tag, "_idle_timeout"}, 8'(busy), 8'h00);
  endtask

  task automatic expectVerdict(input string tag);
    logic expOk;
    int   n;
    expOk = (modelCrc == 8'h00) && (modelCount >= 2) && !modelOverrun;
    n = 0;
    while (!crc_valid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 8'(crc_valid), 8'h01);
    checkOutput({tag, "_ok"}, 8'(crc_ok), 8'(expOk));
    checkOutput({tag, "_crc_init"}, crc_byte, 8'h00);
    tick();
    checkOutput({tag, "_valid_pulse"}, 8'(crc_valid), 8'h00);
    checkOutput({tag, "_ok_held"}, 8'(crc_ok), 8'(expOk));
    modelReset();
  endtask

  initial begin
    logic [7:0] fcs;
    int         len;
    int         gap;
    int         busyCycles;

    reset = 1'b0; rData = 8'h00; newByte = 1'b0; frameEnd = 1'b0;
    modelReset();
    repeat (3) tick();
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_crc", crc_byte, 8'h00);
    checkOutput("rst_valid", 8'(crc_valid), 8'h00);
    checkOutput("rst_ok", 8'(crc_ok), 8'h00);
    checkOutput("rst_overrun", 8'(overrun), 8'h00);
    reset = 1'b1;
    tick();

    // Single byte: exact busy width and remainder.
    applyStimulus(1'b1, 8'h01, 1'b0);
    modelCrc = crcStep(modelCrc, 8'h01);
    modelCount++;
    busyCycles = 0;
    while (busy && busyCycles < 20) begin
      busyCycles++;
      tick();
    end
    checkOutput("single_busy_cycles", 8'(busyCycles), 8'd8);
    checkOutput("single_crc", crc_byte, 8'h07);
    checkOutput("single_crc_model", crc_byte, modelCrc);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("one_byte_frame");

    sendByte(8'h01, 10);
    sendByte(8'h07, 10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("good_0107");

    sendByte(8'h01, 10);
    sendByte(8'h08, 10);
    waitIdle("bad_0108");
    checkOutput("bad_0108_crc", crc_byte, 8'h2D);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("bad_0108");

    for (int i = 0; i < 10; i++) sendByte(8'(i), 10);
    fcs = modelCrc;
    sendByte(fcs, 10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("seq10_gap10");

    // Back-to-back bytes; frameEnd arrives while the FCS is still shifting.
    for (int i = 0; i < 10; i++) sendByte(8'(i), 8);
    fcs = modelCrc;
    sendByte(fcs, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("seq10_gap8_overrun", 8'(overrun), 8'h00);
    expectVerdict("seq10_gap8");

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 8);
      gap = $urandom_range(8, 12);
      for (int i = 0; i < len; i++) sendByte(8'($urandom_range(0, 255)), gap);
      fcs = modelCrc;
      if ($urandom_range(0, 1) == 1) fcs = fcs ^ 8'($urandom_range(1, 255));
      sendByte(fcs, gap);
      applyStimulus(1'b0, 8'h00, 1'b1);
      expectVerdict($sformatf("rand_frame%0d", f));
    end

    // Three strobes in a row: the third lands on a full buffer.
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    modelCrc = crcStep(crcStep(modelCrc, 8'h11), 8'h22);
    modelCount += 2;
    modelOverrun = 1'b1;
    checkOutput("overrun_set", 8'(overrun), 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("overrun_frame");
    checkOutput("overrun_cleared", 8'(overrun), 8'h00);

    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("empty_frame");

    sendByte(8'h00, 10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("below_min_bytes");

    sendByte(8'h01, 10);
    applyStimulus(1'b1, 8'h07, 1'b1);
    modelCrc = crcStep(modelCrc, 8'h07);
    modelCount++;
    expectVerdict("same_edge_end");

    // Reset asserted while the second byte is shifting.
    sendByte(8'h01, 8);
    applyStimulus(1'b1, 8'h07, 1'b0);
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 8'(busy), 8'h00);
    checkOutput("midrst_crc", crc_byte, 8'h00);
    checkOutput("midrst_ok", 8'(crc_ok), 8'h00);
    checkOutput("midrst_overrun", 8'(overrun), 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("midrst_no_valid", 8'(crc_valid), 8'h00);
    end
    reset = 1'b1;
    modelReset();
    tick();
    sendByte(8'h01, 10);
    sendByte(8'h07, 10);
    applyStimulus(1'b0, 8'h00, 1'b1);
    expectVerdict("post_reset_good");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
